// File: rtl/out_bank_checker_if.sv
// -----------------------------------------------------------------------------
// out_bank_checker_if
// Bus bundle between the output-bank checker and its environment.
//   golden stream : golden_valid_i, golden_data_i  (env -> checker)
//                   golden_ready_o                 (checker -> env)
//   SRAM read port: sram_cs_o (one-hot), sram_addr_o (checker -> banks)
//                   sram_rdata_i, bank k at [k*WORD_W +: WORD_W] (banks -> checker)
// Modports:
//   master : the checker side (drives ready, chip-select and address)
//   slave  : the environment side (drives golden stream and read data)
// -----------------------------------------------------------------------------
interface out_bank_checker_if #(
    parameter int NUM_BANKS  = 6,
    parameter int BANK_DEPTH = 32768,
    parameter int WORD_W     = 16,
    parameter int DATA_W     = 8
);
    localparam int ADDR_W = $clog2(BANK_DEPTH);

    logic                        golden_valid_i;
    logic [DATA_W-1:0]           golden_data_i;
    logic                        golden_ready_o;
    logic [NUM_BANKS-1:0]        sram_cs_o;
    logic [ADDR_W-1:0]           sram_addr_o;
    logic [NUM_BANKS*WORD_W-1:0] sram_rdata_i;

    modport master (
        input  golden_valid_i, golden_data_i, sram_rdata_i,
        output golden_ready_o, sram_cs_o, sram_addr_o
    );

    modport slave (
        output golden_valid_i, golden_data_i, sram_rdata_i,
        input  golden_ready_o, sram_cs_o, sram_addr_o
    );
endinterface

// File: rtl/out_bank_checker.sv
// -----------------------------------------------------------------------------
// out_bank_checker
// Walks a window [base, base+len) of a banked output SRAM, reads each word
// while accepting one golden word per transfer, and compares the low DATA_W
// bits (signed) against the golden value within +/-TOL. Counts mismatches
// and reports pass/fail at the end of the window.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           one-cycle request, honoured only when idle
//   base_i, len_i     first global word index / number of words
//   bus (master)      golden stream handshake + SRAM read port
//   busy_o            high from accepted start through the done cycle
//   done_o            one-cycle completion pulse
//   pass_o            no mismatches; held until the next accepted start
//   err_cnt_o         saturating mismatch count
//   first_err_*       index of the first mismatch
//
// Build option:
//   CHECKER_FIRST_ERR_EN  when defined, capture the first mismatching index;
//                         otherwise first_err_valid_o/first_err_idx_o are 0.
// -----------------------------------------------------------------------------
module out_bank_checker #(
    parameter int NUM_BANKS  = 6,
    parameter int BANK_DEPTH = 32768,
    parameter int WORD_W     = 16,
    parameter int DATA_W     = 8,
    parameter int TOL        = 1,
    parameter int IDX_W      = 18,
    parameter int CNT_W      = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [IDX_W-1:0]       base_i,
    input  logic [IDX_W-1:0]       len_i,
    out_bank_checker_if.master     bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [CNT_W-1:0]       err_cnt_o,
    output logic                   first_err_valid_o,
    output logic [IDX_W-1:0]       first_err_idx_o
);
    localparam int ADDR_W  = $clog2(BANK_DEPTH);
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    // Bank number taken straight from the widened global index, so that
    // out-of-range indices never alias onto a real bank.
    localparam int GBANK_W = IDX_W + 1 - ADDR_W;
    localparam longint unsigned TOTAL_WORDS = longint'(NUM_BANKS) * longint'(BANK_DEPTH);
    localparam logic [DATA_W:0] TOL_V = (DATA_W + 1)'(TOL);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]   base_q, len_q, issued_q;
    logic               accept_start, transfer, last_transfer;
    logic [IDX_W:0]     g_wide;
    logic               in_range;
    logic [GBANK_W-1:0] g_bank;

    // Compare stage: one cycle behind the transfer, aligned with read data.
    logic               cmp_valid_q, cmp_oob_q;
    logic [BANK_W-1:0]  cmp_bank_q;
    logic [DATA_W-1:0]  cmp_golden_q;

    logic [WORD_W-1:0]  rd_word;
    logic               unused_word_hi;
    logic signed [DATA_W:0] out_ext, gold_ext, diff;
    logic [DATA_W:0]    abs_diff;
    logic               mismatch;

    logic [CNT_W-1:0]   err_cnt_q;
    logic               pass_hold_q;

    // -------------------------------------------------------------------------
    // Transfer bookkeeping
    // -------------------------------------------------------------------------
    assign accept_start  = (state == IDLE) && start_i;
    assign transfer      = bus.golden_valid_i && bus.golden_ready_o;
    assign last_transfer = transfer && ((issued_q + IDX_W'(1)) == len_q);

    // Sum one bit wider than the index so base+issued cannot wrap into range.
    assign g_wide   = {1'b0, base_q} + {1'b0, issued_q};
    assign in_range = 64'(g_wide) < TOTAL_WORDS;
    assign g_bank   = g_wide[IDX_W:ADDR_W];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next         = state;
        bus.golden_ready_o = 1'b0;
        busy_o             = 1'b1;
        done_o             = 1'b0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_next = (len_i == '0) ? DONE : RUN;
            end
            RUN: begin
                bus.golden_ready_o = (issued_q < len_q);
                if (last_transfer) state_next = DRAIN;
            end
            DRAIN: state_next = DONE;
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // SRAM read request: chip-select only on a transfer to an existing bank
    // -------------------------------------------------------------------------
    always_comb begin
        bus.sram_cs_o   = '0;
        bus.sram_addr_o = '0;
        if (transfer) begin
            bus.sram_addr_o = g_wide[ADDR_W-1:0];
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (in_range && (g_bank == GBANK_W'(k))) bus.sram_cs_o[k] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare: signed, one bit wider than the data so the difference never wraps
    // -------------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (cmp_bank_q == BANK_W'(k)) rd_word = bus.sram_rdata_i[k*WORD_W +: WORD_W];
        end
    end

    // Only the low DATA_W bits of a word take part in the comparison.
    assign unused_word_hi = ^rd_word[WORD_W-1:DATA_W];

    assign out_ext  = {rd_word[DATA_W-1], rd_word[DATA_W-1:0]};
    assign gold_ext = {cmp_golden_q[DATA_W-1], cmp_golden_q};
    assign diff     = out_ext - gold_ext;
    assign abs_diff = diff[DATA_W] ? unsigned'(-diff) : unsigned'(diff);
    assign mismatch = cmp_valid_q && (cmp_oob_q || (abs_diff > TOL_V));

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the compare stage is reset along with the counters so a
            // reset in mid-run throws away the compare that is in flight.
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            err_cnt_q    <= '0;
            pass_hold_q  <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_oob_q    <= 1'b0;
            cmp_bank_q   <= '0;
            cmp_golden_q <= '0;
        end else begin
            if (accept_start) begin
                base_q      <= base_i;
                len_q       <= len_i;
                issued_q    <= '0;
                err_cnt_q   <= '0;
                pass_hold_q <= 1'b0;
            end else begin
                if (transfer) issued_q <= issued_q + IDX_W'(1);
                if (mismatch && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
                if (state == DONE) pass_hold_q <= 1'b1;
            end
            cmp_valid_q <= transfer;
            if (transfer) begin
                cmp_golden_q <= bus.golden_data_i;
                cmp_bank_q   <= g_bank[BANK_W-1:0];
                cmp_oob_q    <= !in_range;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
    // Visible from the done cycle onward; counters are final by then.
    assign pass_o    = ((state == DONE) || pass_hold_q) && (err_cnt_q == '0);

    // -------------------------------------------------------------------------
    // First-mismatch capture
    // -------------------------------------------------------------------------
`ifdef CHECKER_FIRST_ERR_EN
    logic [IDX_W-1:0] cmp_idx_q;
    logic             first_err_valid_q;
    logic [IDX_W-1:0] first_err_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_idx_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            if (transfer) cmp_idx_q <= g_wide[IDX_W-1:0];
            if (accept_start) begin
                first_err_valid_q <= 1'b0;
                first_err_idx_q   <= '0;
            end else if (mismatch && !first_err_valid_q) begin
                first_err_valid_q <= 1'b1;
                first_err_idx_q   <= cmp_idx_q;
            end
        end
    end

    assign first_err_valid_o = first_err_valid_q;
    assign first_err_idx_o   = first_err_idx_q;
`else
    assign first_err_valid_o = 1'b0;
    assign first_err_idx_o   = '0;
`endif

endmodule

// File: tb/tb_out_bank_checker.sv
// -----------------------------------------------------------------------------
// tb_out_bank_checker
// Directed bench for out_bank_checker. A behavioural 1-cycle-latency SRAM
// answers chip-selects from a pattern function plus sparse overrides; golden
// words come from the same pattern unless overridden. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_out_bank_checker;
    localparam int NB    = 6;
    localparam int BD    = 32768;
    localparam int WW    = 16;
    localparam int DW    = 8;
    localparam int IDX_W = 18;
    localparam int CNT_W = 18;
`ifdef CHECKER_FIRST_ERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [IDX_W-1:0] base_i, len_i;
    logic             busy_o, done_o, pass_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             first_err_valid_o;
    logic [IDX_W-1:0] first_err_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    out_bank_checker_if #(.NUM_BANKS(NB), .BANK_DEPTH(BD), .WORD_W(WW), .DATA_W(DW)) bus ();

    out_bank_checker dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .base_i            (base_i),
        .len_i             (len_i),
        .bus               (bus),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .pass_o            (pass_o),
        .err_cnt_o         (err_cnt_o),
        .first_err_valid_o (first_err_valid_o),
        .first_err_idx_o   (first_err_idx_o)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM content model ----------------
    logic [15:0] mem_ovr  [int];
    logic [7:0]  gold_ovr [int];

    function automatic logic [15:0] mem_word(input int g);
        if (mem_ovr.exists(g)) return mem_ovr[g];
        return {8'h5A, 8'(g * 7 + 3)};
    endfunction

    function automatic logic [7:0] golden_of(input int g);
        logic [15:0] w;
        if (gold_ovr.exists(g)) return gold_ovr[g];
        w = mem_word(g);
        return w[7:0];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (bus.sram_cs_o[k]) bus.sram_rdata_i[k*WW +: WW] <= mem_word(k * BD + int'(bus.sram_addr_o));
        end
    end

    // ---------------- run recorder ----------------
    int r_bank[$];
    int r_addr[$];
    int r_cs_cnt, r_gap_reads, r_bad_cs, r_done_cyc, r_done_cnt;
    int r_err, r_pass, r_fev, r_fei;

    // Start a check, then observe cycles 1..max_cyc after the accepting edge.
    task automatic run_check(input int base, input int len, input bit toggle, input int max_cyc);
        int idx;
        r_bank.delete(); r_addr.delete();
        r_cs_cnt = 0; r_gap_reads = 0; r_bad_cs = 0; r_done_cyc = -1; r_done_cnt = 0;
        r_err = -1; r_pass = -1; r_fev = -1; r_fei = -1;
        @(negedge clk);
        start_i = 1'b1; base_i = IDX_W'(base); len_i = IDX_W'(len); bus.golden_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        idx = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.golden_valid_i = toggle ? ((cyc % 2) == 1) : 1'b1;
            bus.golden_data_i  = golden_of(base + idx);
            #1;
            if (bus.sram_cs_o != '0) begin
                r_cs_cnt++;
                if (!$onehot(bus.sram_cs_o)) r_bad_cs++;
                if (!bus.golden_valid_i) r_gap_reads++;
                for (int k = 0; k < NB; k++) if (bus.sram_cs_o[k]) r_bank.push_back(k);
                r_addr.push_back(int'(bus.sram_addr_o));
            end
            if (done_o) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = cyc; r_err = int'(err_cnt_o); r_pass = int'(pass_o);
                    r_fev = int'(first_err_valid_o); r_fei = int'(first_err_idx_o);
                end
            end
            if (bus.golden_valid_i && bus.golden_ready_o) idx++;
            @(negedge clk);
        end
        bus.golden_valid_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; base_i = '0; len_i = IDX_W'(4);
        bus.golden_valid_i = 1'b1; bus.golden_data_i = '0;
        repeat (3) @(negedge clk);
        start_i = 1'b0; bus.golden_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.golden_ready_o !== 1'b0 || bus.sram_cs_o !== '0 || bus.sram_addr_o !== '0) begin
            n_fail++; $display("FAIL reset_bus: ready=%b cs=%b addr=%0d want 0/0/0", bus.golden_ready_o, bus.sram_cs_o, bus.sram_addr_o); end
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b pass=%b want 0/0/0", busy_o, done_o, pass_o); end
        n_checks++; if (err_cnt_o !== '0 || first_err_valid_o !== 1'b0 || first_err_idx_o !== '0) begin
            n_fail++; $display("FAIL reset_err: cnt=%0d fev=%b fei=%0d want 0/0/0", err_cnt_o, first_err_valid_o, first_err_idx_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int bad;
        run_check(0, 16, 1'b0, 20);
        n_checks++; if (r_cs_cnt != 16) begin n_fail++; $display("FAIL basic_cs_count: got %0d want 16", r_cs_cnt); end
        n_checks++; if (r_done_cyc != 18) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 18", r_done_cyc); end
        n_checks++; if (r_err != 0 || r_pass != 1) begin n_fail++; $display("FAIL basic_result: err=%0d pass=%0d want 0/1", r_err, r_pass); end
        bad = 0;
        for (int i = 0; i < r_addr.size(); i++) if (r_addr[i] != i || r_bank[i] != 0) bad++;
        n_checks++; if (bad != 0 || r_bad_cs != 0) begin n_fail++; $display("FAIL basic_addr_seq: bad=%0d non_onehot=%0d want 0/0", bad, r_bad_cs); end
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_after_done: busy=%b done=%b pass=%b want 0/0/1", busy_o, done_o, pass_o); end
        n_checks++; if (r_done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d want 1", r_done_cnt); end
    endtask

    task automatic test_tolerance();
        mem_ovr[5] = 16'h0003; gold_ovr[5] = 8'd4;
        mem_ovr[6] = 16'h0005; gold_ovr[6] = 8'd7;
        run_check(0, 8, 1'b0, 12);
        n_checks++; if (r_err != 1 || r_pass != 0) begin n_fail++; $display("FAIL tol_result: err=%0d pass=%0d want 1/0", r_err, r_pass); end
        n_checks++; if (r_fev != int'(FE_ON) || r_fei != (FE_ON ? 6 : 0)) begin
            n_fail++; $display("FAIL tol_first_err: valid=%0d idx=%0d want %0d/%0d", r_fev, r_fei, FE_ON, FE_ON ? 6 : 0); end
        n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL tol_pass_held: got %b want 0", pass_o); end
    endtask

    task automatic test_bank_cross();
        int exp_bank[4] = '{0, 0, 1, 1};
        int exp_addr[4] = '{32766, 32767, 0, 1};
        run_check(32766, 4, 1'b0, 8);
        n_checks++; if (r_addr.size() != 4) begin n_fail++; $display("FAIL cross_count: got %0d want 4", r_addr.size()); end
        for (int i = 0; i < 4 && i < r_addr.size(); i++) begin
            n_checks++; if (r_bank[i] != exp_bank[i] || r_addr[i] != exp_addr[i]) begin
                n_fail++; $display("FAIL cross_read%0d: bank=%0d addr=%0d want %0d/%0d", i, r_bank[i], r_addr[i], exp_bank[i], exp_addr[i]); end
        end
        n_checks++; if (r_err != 0 || r_pass != 1) begin n_fail++; $display("FAIL cross_result: err=%0d pass=%0d want 0/1", r_err, r_pass); end
    endtask

    task automatic test_signed_extremes();
        mem_ovr[100] = 16'h337F; gold_ovr[100] = 8'h80;   // 127 vs -128
        mem_ovr[101] = 16'h1280; gold_ovr[101] = 8'h7F;   // -128 vs 127
        mem_ovr[102] = 16'hFFFF; gold_ovr[102] = 8'h00;   // -1 vs 0, within TOL
        run_check(100, 3, 1'b0, 7);
        n_checks++; if (r_err != 2 || r_pass != 0) begin n_fail++; $display("FAIL extreme_result: err=%0d pass=%0d want 2/0", r_err, r_pass); end
        n_checks++; if (r_done_cyc != 5) begin n_fail++; $display("FAIL extreme_done_cycle: got %0d want 5", r_done_cyc); end
        n_checks++; if (r_fev != int'(FE_ON) || r_fei != (FE_ON ? 100 : 0)) begin
            n_fail++; $display("FAIL extreme_first_err: valid=%0d idx=%0d want %0d/%0d", r_fev, r_fei, FE_ON, FE_ON ? 100 : 0); end
    endtask

    task automatic test_out_of_range();
        run_check(196607, 2, 1'b0, 6);
        n_checks++; if (r_cs_cnt != 1) begin n_fail++; $display("FAIL oob_cs_count: got %0d want 1", r_cs_cnt); end
        n_checks++; if (r_cs_cnt == 1 && (r_bank[0] != 5 || r_addr[0] != 32767)) begin
            n_fail++; $display("FAIL oob_last_word: bank=%0d addr=%0d want 5/32767", r_bank[0], r_addr[0]); end
        n_checks++; if (r_err != 1 || r_pass != 0) begin n_fail++; $display("FAIL oob_result: err=%0d pass=%0d want 1/0", r_err, r_pass); end
        n_checks++; if (r_fev != int'(FE_ON) || r_fei != (FE_ON ? 196608 : 0)) begin
            n_fail++; $display("FAIL oob_first_err: valid=%0d idx=%0d want %0d/%0d", r_fev, r_fei, FE_ON, FE_ON ? 196608 : 0); end
    endtask

    task automatic test_valid_gaps();
        int bad;
        run_check(40, 8, 1'b1, 19);
        n_checks++; if (r_cs_cnt != 8 || r_gap_reads != 0) begin
            n_fail++; $display("FAIL gaps_reads: reads=%0d during_low=%0d want 8/0", r_cs_cnt, r_gap_reads); end
        bad = 0;
        for (int i = 0; i < r_addr.size(); i++) if (r_addr[i] != 40 + i) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL gaps_addr_seq: bad=%0d want 0", bad); end
        n_checks++; if (r_done_cyc != 17 || r_err != 0 || r_pass != 1) begin
            n_fail++; $display("FAIL gaps_result: done_cyc=%0d err=%0d pass=%0d want 17/0/1", r_done_cyc, r_err, r_pass); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] w;
        w = mem_word(501); gold_ovr[501] = w[7:0] ^ 8'h40;
        w = mem_word(504); gold_ovr[504] = w[7:0] ^ 8'h40;
        @(negedge clk);
        start_i = 1'b1; base_i = IDX_W'(500); len_i = IDX_W'(16); bus.golden_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            bus.golden_valid_i = 1'b1;
            bus.golden_data_i  = golden_of(500 + cyc - 1);
            if (cyc == 5) rst = 1'b1;
            #1;
            if (cyc == 4) begin
                n_checks++; if (err_cnt_o !== CNT_W'(1)) begin n_fail++; $display("FAIL midrst_pre_cnt: got %0d want 1", err_cnt_o); end
            end
            if (cyc == 5) begin
                n_checks++; if (!(bus.golden_ready_o && bus.sram_cs_o == 6'b000001 && bus.sram_addr_o == 15'd504)) begin
                    n_fail++; $display("FAIL midrst_5th_xfer: ready=%b cs=%b addr=%0d want 1/000001/504", bus.golden_ready_o, bus.sram_cs_o, bus.sram_addr_o); end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.golden_ready_o !== 1'b0 || bus.sram_cs_o !== '0 || bus.sram_addr_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: ready=%b cs=%b addr=%0d busy=%b done=%b want all 0", bus.golden_ready_o, bus.sram_cs_o, bus.sram_addr_o, busy_o, done_o); end
        n_checks++; if (pass_o !== 1'b0 || err_cnt_o !== '0 || first_err_valid_o !== 1'b0 || first_err_idx_o !== '0) begin
            n_fail++; $display("FAIL midrst_status: pass=%b cnt=%0d fev=%b fei=%0d want all 0", pass_o, err_cnt_o, first_err_valid_o, first_err_idx_o); end
        @(negedge clk);
        #1;
        n_checks++; if (err_cnt_o !== '0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_discard: cnt=%0d busy=%b want 0/0", err_cnt_o, busy_o); end
        bus.golden_valid_i = 1'b0;

        run_check(0, 4, 1'b0, 8);
        n_checks++; if (r_cs_cnt != 4 || r_done_cyc != 6 || r_err != 0 || r_pass != 1) begin
            n_fail++; $display("FAIL midrst_restart: reads=%0d done_cyc=%0d err=%0d pass=%0d want 4/6/0/1", r_cs_cnt, r_done_cyc, r_err, r_pass); end

        run_check(0, 0, 1'b0, 4);
        n_checks++; if (r_done_cnt != 1 || r_done_cyc < 1 || r_done_cyc > 2 || r_pass != 1 || r_cs_cnt != 0) begin
            n_fail++; $display("FAIL len0: done_pulses=%0d done_cyc=%0d pass=%0d reads=%0d want 1/<=2/1/0", r_done_cnt, r_done_cyc, r_pass, r_cs_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_tolerance();
        test_bank_cross();
        test_signed_extremes();
        test_out_of_range();
        test_valid_gaps();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
